// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state types and data helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

   localparam int DATA_WIDTH        = 8;
   localparam int WORD_WIDTH        = 32;
   localparam int RAM_ADDRESS_WIDTH = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

   localparam logic [2:0] SIZE_BYTE = 3'd1;
   localparam logic [2:0] SIZE_HALF = 3'd2;
   localparam logic [2:0] SIZE_WORD = 3'd4;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   typedef enum logic [1:0] {KIND_FETCH, KIND_LOAD, KIND_STORE} kind_t;

   // Any size encoding other than 1 or 2 is treated as a full word so a transfer always terminates.
   function automatic logic [2:0] beatCount(input logic [2:0] size);
      case (size)
         SIZE_BYTE: beatCount = SIZE_BYTE;
         SIZE_HALF: beatCount = SIZE_HALF;
         default:   beatCount = SIZE_WORD;
      endcase
   endfunction

   function automatic logic [WORD_WIDTH-1:0] extendLoad(input logic [WORD_WIDTH-1:0] raw,
                                                        input logic [2:0]            size,
                                                        input logic                  isSigned);
      case (size)
         SIZE_BYTE: extendLoad = {{24{isSigned & raw[7]}}, raw[7:0]};
         SIZE_HALF: extendLoad = {{16{isSigned & raw[15]}}, raw[15:0]};
         default:   extendLoad = raw;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-port bundle of the memory controller; master is the controller side.
interface mem_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDRESS_WIDTH
);

   logic                  in_misbranch;

   logic                  in_fetch_req;
   logic [ADDR_W-1:0]     in_fetch_addr;
   logic                  out_fetch_done;
   logic [WORD_WIDTH-1:0] out_fetch_data;

   logic                  in_load_req;
   logic [ADDR_W-1:0]     in_load_addr;
   logic [2:0]            in_load_size;
   logic                  in_load_signed;
   logic                  out_load_done;
   logic [WORD_WIDTH-1:0] out_load_data;

   logic                  in_store_req;
   logic [ADDR_W-1:0]     in_store_addr;
   logic [2:0]            in_store_size;
   logic [WORD_WIDTH-1:0] in_store_data;
   logic                  out_store_done;

   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] mem_dout;
   logic [ADDR_W-1:0]     mem_a;
   logic                  mem_wr;
   logic                  io_buffer_full;

   modport master (
      input  in_misbranch,
      input  in_fetch_req, in_fetch_addr,
      output out_fetch_done, out_fetch_data,
      input  in_load_req, in_load_addr, in_load_size, in_load_signed,
      output out_load_done, out_load_data,
      input  in_store_req, in_store_addr, in_store_size, in_store_data,
      output out_store_done,
      input  mem_din, io_buffer_full,
      output mem_dout, mem_a, mem_wr
   );

   modport slave (
      output in_misbranch,
      output in_fetch_req, in_fetch_addr,
      input  out_fetch_done, out_fetch_data,
      output in_load_req, in_load_addr, in_load_size, in_load_signed,
      input  out_load_done, out_load_data,
      output in_store_req, in_store_addr, in_store_size, in_store_data,
      input  out_store_done,
      output mem_din, io_buffer_full,
      input  mem_dout, mem_a, mem_wr
   );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch, load and store requesters onto the 8-bit RAM/IO port, serialising
// each access into byte beats and assembling little-endian read data.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int         ADDR_W     = RAM_ADDRESS_WIDTH,
   parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
)(
   input logic        clk,
   input logic        rst,
   input logic        rdy,
   mem_ctrl_if.master bus
);

   state_t                r_state, w_state;
   kind_t                 r_kind, w_kind;
   logic [ADDR_W-1:0]     r_addr, w_addr;
   logic [2:0]            r_size, w_size;
   logic                  r_signed, w_signed;
   logic [WORD_WIDTH-1:0] r_wdata, w_wdata;
   logic [WORD_WIDTH-1:0] r_rdata, w_rdata;
   logic [2:0]            r_cnt, w_cnt;

   logic                  r_loadPend, w_loadPend;
   logic [ADDR_W-1:0]     r_loadAddr, w_loadAddr;
   logic [2:0]            r_loadSize, w_loadSize;
   logic                  r_loadSigned, w_loadSigned;

   logic                  r_storePend, w_storePend;
   logic [ADDR_W-1:0]     r_storeAddr, w_storeAddr;
   logic [2:0]            r_storeSize, w_storeSize;
   logic [WORD_WIDTH-1:0] r_storeData, w_storeData;

   logic [ADDR_W-1:0]     r_memA, w_memA;
   logic [DATA_WIDTH-1:0] r_memDout, w_memDout;
   logic                  r_memWr, w_memWr;

   logic                  r_fetchDone, w_fetchDone;
   logic [WORD_WIDTH-1:0] r_fetchData, w_fetchData;
   logic                  r_loadDone, w_loadDone;
   logic [WORD_WIDTH-1:0] r_loadData, w_loadData;
   logic                  r_storeDone, w_storeDone;

   logic                  w_ioBlocked;
   logic [1:0]            w_rdLane;
   logic [WORD_WIDTH-1:0] w_result;

   // All state advances only when the core is ready; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_kind       <= KIND_FETCH;
         r_addr       <= '0;
         r_size       <= '0;
         r_signed     <= FALSE;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_cnt        <= '0;
         r_loadPend   <= FALSE;
         r_loadAddr   <= '0;
         r_loadSize   <= '0;
         r_loadSigned <= FALSE;
         r_storePend  <= FALSE;
         r_storeAddr  <= '0;
         r_storeSize  <= '0;
         r_storeData  <= '0;
         r_memA       <= '0;
         r_memDout    <= '0;
         r_memWr      <= FALSE;
         r_fetchDone  <= FALSE;
         r_fetchData  <= '0;
         r_loadDone   <= FALSE;
         r_loadData   <= '0;
         r_storeDone  <= FALSE;
      end else if (rdy) begin
         r_state      <= w_state;
         r_kind       <= w_kind;
         r_addr       <= w_addr;
         r_size       <= w_size;
         r_signed     <= w_signed;
         r_wdata      <= w_wdata;
         r_rdata      <= w_rdata;
         r_cnt        <= w_cnt;
         r_loadPend   <= w_loadPend;
         r_loadAddr   <= w_loadAddr;
         r_loadSize   <= w_loadSize;
         r_loadSigned <= w_loadSigned;
         r_storePend  <= w_storePend;
         r_storeAddr  <= w_storeAddr;
         r_storeSize  <= w_storeSize;
         r_storeData  <= w_storeData;
         r_memA       <= w_memA;
         r_memDout    <= w_memDout;
         r_memWr      <= w_memWr;
         r_fetchDone  <= w_fetchDone;
         r_fetchData  <= w_fetchData;
         r_loadDone   <= w_loadDone;
         r_loadData   <= w_loadData;
         r_storeDone  <= w_storeDone;
      end
   end

   // Incoming pulses are merged into the slots before arbitration, so a pulse arriving
   // in an idle cycle can be granted on the very edge that would otherwise latch it.
   always_comb begin
      w_state      = r_state;
      w_kind       = r_kind;
      w_addr       = r_addr;
      w_size       = r_size;
      w_signed     = r_signed;
      w_wdata      = r_wdata;
      w_rdata      = r_rdata;
      w_cnt        = r_cnt;
      w_loadPend   = r_loadPend;
      w_loadAddr   = r_loadAddr;
      w_loadSize   = r_loadSize;
      w_loadSigned = r_loadSigned;
      w_storePend  = r_storePend;
      w_storeAddr  = r_storeAddr;
      w_storeSize  = r_storeSize;
      w_storeData  = r_storeData;
      w_memA       = r_memA;
      w_memDout    = r_memDout;
      w_memWr      = FALSE;
      w_fetchDone  = FALSE;
      w_fetchData  = r_fetchData;
      w_loadDone   = FALSE;
      w_loadData   = r_loadData;
      w_storeDone  = FALSE;
      w_rdLane     = r_cnt[1:0] - 2'd1;
      w_result     = '0;

      if (bus.in_store_req) begin
         w_storePend = TRUE;
         w_storeAddr = bus.in_store_addr;
         w_storeSize = beatCount(bus.in_store_size);
         w_storeData = bus.in_store_data;
      end
      if (bus.in_load_req) begin
         w_loadPend   = TRUE;
         w_loadAddr   = bus.in_load_addr;
         w_loadSize   = beatCount(bus.in_load_size);
         w_loadSigned = bus.in_load_signed;
      end
      if (bus.in_misbranch) begin
         w_loadPend = FALSE;
      end

      // A blocked IO store also holds back load and fetch so nothing overtakes the commit.
      w_ioBlocked = w_storePend && (w_storeAddr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;

      case (r_state)
         IDLE: begin
            if (w_storePend) begin
               if (!w_ioBlocked) begin
                  w_state     = WRITE;
                  w_kind      = KIND_STORE;
                  w_addr      = w_storeAddr;
                  w_size      = w_storeSize;
                  w_signed    = FALSE;
                  w_wdata     = w_storeData;
                  w_cnt       = 3'd1;
                  w_memA      = w_storeAddr;
                  w_memDout   = w_storeData[DATA_WIDTH-1:0];
                  w_memWr     = TRUE;
                  w_storePend = FALSE;
               end
            end else if (w_loadPend) begin
               w_state    = READ;
               w_kind     = KIND_LOAD;
               w_addr     = w_loadAddr;
               w_size     = w_loadSize;
               w_signed   = w_loadSigned;
               w_rdata    = '0;
               w_cnt      = 3'd0;
               w_memA     = w_loadAddr;
               w_loadPend = FALSE;
            end else if (bus.in_fetch_req && !bus.in_misbranch) begin
               w_state  = READ;
               w_kind   = KIND_FETCH;
               w_addr   = bus.in_fetch_addr;
               w_size   = SIZE_WORD;
               w_signed = FALSE;
               w_rdata  = '0;
               w_cnt    = 3'd0;
               w_memA   = bus.in_fetch_addr;
            end
         end

         // RAM returns a byte one cycle after its address, so byte j lands two edges after beat j.
         READ: begin
            if (bus.in_misbranch) begin
               w_state = IDLE;
               w_cnt   = 3'd0;
            end else begin
               if (({1'b0, r_cnt} + 4'd1) < {1'b0, r_size}) begin
                  w_memA = r_addr + ADDR_W'(r_cnt + 3'd1);
               end
               if (r_cnt != 3'd0) begin
                  w_rdata[{w_rdLane, 3'b000} +: DATA_WIDTH] = bus.mem_din;
               end
               if (r_cnt == r_size) begin
                  w_result = extendLoad(w_rdata, r_size, r_signed);
                  if (r_kind == KIND_LOAD) begin
                     w_loadDone = TRUE;
                     w_loadData = w_result;
                  end else begin
                     w_fetchDone = TRUE;
                     w_fetchData = w_result;
                  end
                  w_state = IDLE;
                  w_cnt   = 3'd0;
               end else begin
                  w_cnt = r_cnt + 3'd1;
               end
            end
         end

         // Committed stores always run to completion, flush or not.
         WRITE: begin
            if (r_cnt == r_size) begin
               w_storeDone = TRUE;
               w_state     = IDLE;
               w_cnt       = 3'd0;
            end else begin
               w_memA    = r_addr + ADDR_W'(r_cnt);
               w_memDout = r_wdata[{r_cnt[1:0], 3'b000} +: DATA_WIDTH];
               w_memWr   = TRUE;
               w_cnt     = r_cnt + 3'd1;
            end
         end

         default: begin
            w_state = IDLE;
            w_cnt   = 3'd0;
         end
      endcase
   end

   assign bus.out_fetch_done = r_fetchDone;
   assign bus.out_fetch_data = r_fetchData;
   assign bus.out_load_done  = r_loadDone;
   assign bus.out_load_data  = r_loadData;
   assign bus.out_store_done = r_storeDone;
   assign bus.mem_a          = r_memA;
   assign bus.mem_dout       = r_memDout;
   assign bus.mem_wr         = r_memWr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model and done/write monitors.
module tb_mem_ctrl;

   localparam int KIND_F = 1;
   localparam int KIND_L = 2;
   localparam int KIND_S = 3;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   mem_ctrl_if bus ();

   mem_ctrl #(.ADDR_W(32), .IO_ADDR_HI(2'b11)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [0:262143];

   int checkCount = 0;
   int failCount  = 0;
   int fetchDoneCnt = 0;
   int loadDoneCnt  = 0;
   int storeDoneCnt = 0;
   int wrCount      = 0;
   int protoViol    = 0;
   int orderLog [$];
   logic [31:0] wrAddr [$];
   logic [7:0]  wrData [$];

   // RAM answers one cycle after the address and writes on the edge closing a write beat.
   always @(posedge clk) begin
      if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[17:0]];
   end

   always @(negedge clk) begin
      if (bus.out_store_done) begin storeDoneCnt++; orderLog.push_back(KIND_S); end
      if (bus.out_load_done)  begin loadDoneCnt++;  orderLog.push_back(KIND_L); end
      if (bus.out_fetch_done) begin fetchDoneCnt++; orderLog.push_back(KIND_F); end
      if (bus.mem_wr) begin
         wrCount++;
         wrAddr.push_back(bus.mem_a);
         wrData.push_back(bus.mem_dout);
      end
      if ((bus.in_load_req && dut.r_loadPend) || (bus.in_store_req && dut.r_storePend))
         protoViol++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one request at a negedge; load/store pulses last exactly one cycle, fetch stays high.
   task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [2:0] size,
                                input logic sgn, input logic [31:0] data);
      case (kind)
         KIND_F: begin bus.in_fetch_addr = addr; bus.in_fetch_req = 1'b1; end
         KIND_L: begin
            bus.in_load_addr = addr; bus.in_load_size = size;
            bus.in_load_signed = sgn; bus.in_load_req = 1'b1;
         end
         default: begin
            bus.in_store_addr = addr; bus.in_store_size = size;
            bus.in_store_data = data; bus.in_store_req = 1'b1;
         end
      endcase
      @(negedge clk);
      bus.in_load_req  = 1'b0;
      bus.in_store_req = 1'b0;
   endtask

   function automatic logic doneOf(input int kind);
      case (kind)
         KIND_F:  doneOf = bus.out_fetch_done;
         KIND_L:  doneOf = bus.out_load_done;
         default: doneOf = bus.out_store_done;
      endcase
   endfunction

   // lat = edges from the grant edge to the done edge, -1 if the budget expires.
   task automatic waitDone(input int kind, output int lat);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (doneOf(kind)) begin lat = i; break; end
      end
      if (kind == KIND_F) bus.in_fetch_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int base;

      rst = 1'b1; rdy = 1'b1;
      bus.in_misbranch = 1'b0; bus.io_buffer_full = 1'b0;
      bus.in_fetch_req = 1'b0; bus.in_fetch_addr = '0;
      bus.in_load_req = 1'b0;  bus.in_load_addr = '0; bus.in_load_size = '0; bus.in_load_signed = 1'b0;
      bus.in_store_req = 1'b0; bus.in_store_addr = '0; bus.in_store_size = '0; bus.in_store_data = '0;

      ram['h100] = 8'h13; ram['h101] = 8'h05; ram['h102] = 8'h00; ram['h103] = 8'h00;
      ram['h104] = 8'h93; ram['h105] = 8'h00; ram['h106] = 8'h10; ram['h107] = 8'h00;
      ram['h200] = 8'h80;
      ram['h210] = 8'h34; ram['h211] = 8'hF2;
      ram['h300] = 8'h00; ram['h301] = 8'h00; ram['h302] = 8'h77;
      ram['h400] = 8'h00;
      ram['h500] = 8'h11; ram['h501] = 8'h22; ram['h502] = 8'h33; ram['h503] = 8'h44;
      ram['h600] = 8'h00; ram['h601] = 8'h00; ram['h602] = 8'h00; ram['h603] = 8'h00;
      ram['h30000] = 8'h00;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_mem_wr", bus.mem_wr, 0);
      checkOutput("rst_mem_a", bus.mem_a, 0);
      checkOutput("rst_mem_dout", bus.mem_dout, 0);
      checkOutput("rst_dones", {bus.out_fetch_done, bus.out_load_done, bus.out_store_done}, 0);
      checkOutput("rst_fetch_data", bus.out_fetch_data, 0);
      checkOutput("rst_load_data", bus.out_load_data, 0);

      // Instruction fetch
      applyStimulus(KIND_F, 32'h100, 3'd4, 1'b0, 0);
      waitDone(KIND_F, lat);
      checkOutput("fetch_latency", 64'(lat), 5);
      checkOutput("fetch_data", bus.out_fetch_data, 32'h0000_0513);
      @(negedge clk);
      checkOutput("fetch_done_once", 64'(fetchDoneCnt), 1);

      // Byte and half loads, signed and unsigned
      applyStimulus(KIND_L, 32'h200, 3'd1, 1'b1, 0);
      waitDone(KIND_L, lat);
      checkOutput("lb_latency", 64'(lat), 2);
      checkOutput("lb_data", bus.out_load_data, 32'hFFFF_FF80);
      applyStimulus(KIND_L, 32'h200, 3'd1, 1'b0, 0);
      waitDone(KIND_L, lat);
      checkOutput("lbu_latency", 64'(lat), 2);
      checkOutput("lbu_data", bus.out_load_data, 32'h0000_0080);
      applyStimulus(KIND_L, 32'h210, 3'd2, 1'b1, 0);
      waitDone(KIND_L, lat);
      checkOutput("lh_data", bus.out_load_data, 32'hFFFF_F234);

      // Half-word store
      wrCount = 0; wrAddr.delete(); wrData.delete();
      applyStimulus(KIND_S, 32'h300, 3'd2, 1'b0, 32'h1234_ABCD);
      waitDone(KIND_S, lat);
      checkOutput("sh_latency", 64'(lat), 2);
      @(negedge clk);
      checkOutput("sh_wr_cycles", 64'(wrCount), 2);
      checkOutput("sh_beat0", {wrAddr[0], wrData[0]}, {32'h300, 8'hCD});
      checkOutput("sh_beat1", {wrAddr[1], wrData[1]}, {32'h301, 8'hAB});
      checkOutput("sh_ram", {ram['h302], ram['h301], ram['h300]}, 24'h77_AB_CD);

      // Simultaneous store, load and fetch
      orderLog.delete();
      bus.in_store_addr = 32'h400; bus.in_store_size = 3'd1; bus.in_store_data = 32'h0000_005A; bus.in_store_req = 1'b1;
      bus.in_load_addr = 32'h500; bus.in_load_size = 3'd4; bus.in_load_signed = 1'b0; bus.in_load_req = 1'b1;
      bus.in_fetch_addr = 32'h100; bus.in_fetch_req = 1'b1;
      @(negedge clk);
      bus.in_store_req = 1'b0; bus.in_load_req = 1'b0;
      waitDone(KIND_F, lat);
      @(negedge clk);
      checkOutput("prio_count", 64'(orderLog.size()), 3);
      checkOutput("prio_order", {orderLog[0], orderLog[1], orderLog[2]}, {KIND_S, KIND_L, KIND_F});
      checkOutput("prio_lw_data", bus.out_load_data, 32'h4433_2211);
      checkOutput("prio_fetch_data", bus.out_fetch_data, 32'h0000_0513);
      checkOutput("prio_sb_ram", ram['h400], 8'h5A);

      // IO store held off by a full UART buffer
      orderLog.delete(); wrCount = 0;
      base = fetchDoneCnt;
      bus.io_buffer_full = 1'b1;
      bus.in_fetch_addr = 32'h104; bus.in_fetch_req = 1'b1;
      applyStimulus(KIND_S, 32'h0003_0000, 3'd1, 1'b0, 32'h0000_00A5);
      repeat (10) @(negedge clk);
      checkOutput("io_stall_no_write", 64'(wrCount), 0);
      checkOutput("io_stall_no_fetch", 64'(fetchDoneCnt - base), 0);
      bus.io_buffer_full = 1'b0;
      waitDone(KIND_F, lat);
      @(negedge clk);
      checkOutput("io_order", {orderLog.size(), orderLog[0], orderLog[1]}, {32'd2, KIND_S, KIND_F});
      checkOutput("io_ram", ram['h30000], 8'hA5);
      checkOutput("io_fetch_data", bus.out_fetch_data, 32'h0010_0093);

      // Load aborted by a flush at beat 2, then a normal fetch
      base = loadDoneCnt;
      applyStimulus(KIND_L, 32'h500, 3'd4, 1'b0, 0);
      @(negedge clk);
      bus.in_misbranch = 1'b1;
      @(negedge clk);
      bus.in_misbranch = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("misbr_no_load_done", 64'(loadDoneCnt - base), 0);
      checkOutput("misbr_mem_wr", bus.mem_wr, 0);
      applyStimulus(KIND_F, 32'h104, 3'd4, 1'b0, 0);
      waitDone(KIND_F, lat);
      checkOutput("misbr_fetch_latency", 64'(lat), 5);
      checkOutput("misbr_fetch_data", bus.out_fetch_data, 32'h0010_0093);

      // Store under a flush still completes
      wrCount = 0;
      base = storeDoneCnt;
      applyStimulus(KIND_S, 32'h600, 3'd4, 1'b0, 32'hDEAD_BEEF);
      @(negedge clk);
      bus.in_misbranch = 1'b1;
      @(negedge clk);
      bus.in_misbranch = 1'b0;
      waitDone(KIND_S, lat);
      @(negedge clk);
      checkOutput("misbr_store_done", 64'(storeDoneCnt - base), 1);
      checkOutput("misbr_store_wr_cycles", 64'(wrCount), 4);
      checkOutput("misbr_store_ram", {ram['h603], ram['h602], ram['h601], ram['h600]}, 32'hDEAD_BEEF);

      // Reset in the middle of a fetch drops it silently
      base = fetchDoneCnt;
      applyStimulus(KIND_F, 32'h100, 3'd4, 1'b0, 0);
      rst = 1'b1; bus.in_fetch_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("rst_mid_no_done", 64'(fetchDoneCnt - base), 0);
      checkOutput("rst_mid_mem_a", bus.mem_a, 0);

      checkOutput("protocol_violations", 64'(protoViol), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single owner of the 8-bit, byte-addressed RAM/IO port.
- Shares the port between three requesters:
  - instruction fetcher: 32-bit instruction reads;
  - store/load buffer: 1/2/4-byte loads, signed or unsigned;
  - reorder buffer: committed 1/2/4-byte stores.
- Serialises every access into byte beats, assembles little-endian read data, and returns one-cycle done strobes.

Parameters:
- ADDR_W, 32, address width of all requesters and the RAM port.
- IO_ADDR_HI, 2'b11, value of addr[17:16] that selects the IO region.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs freeze
- in_misbranch  in  1  flush; aborts reads
- in_fetch_req  in  1  level; held until out_fetch_done
- in_fetch_addr  in  ADDR_W  instruction address
- out_fetch_done  out  1  one-cycle pulse
- out_fetch_data  out  32  instruction word, valid with done
- in_load_req  in  1  one-cycle pulse from the SLB
- in_load_addr  in  ADDR_W  load address
- in_load_size  in  3  load size, 1, 2 or 4 bytes
- in_load_signed  in  1  sign-extend 1/2-byte results
- out_load_done  out  1  one-cycle pulse
- out_load_data  out  32  extended load result
- in_store_req  in  1  one-cycle pulse from the ROB commit
- in_store_addr  in  ADDR_W  store address
- in_store_size  in  3  store size, 1, 2 or 4 bytes
- in_store_data  in  32  store data, low bytes used
- out_store_done  out  1  one-cycle pulse
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset: state IDLE; load/store pending flags cleared.
  - Outputs: mem_wr=0, mem_a=0, mem_dout=0, all done strobes=0, all data outputs=0.
  - Reset mid-transfer aborts immediately; no done strobe is issued.
- Pending slots:
  - A load or store pulse is latched, with its address, size, signed flag and data, into that requester's slot.
  - The slot clears at grant.
  - A second pulse while the slot is full is a protocol violation; the bench asserts it never happens.
  - Fetch is level-sensitive and is not latched.
- States: IDLE, READ, WRITE.
- Arbitration: evaluated only in IDLE; fixed priority store > load > fetch; non-preemptive.
  - A store whose addr[17:16]==IO_ADDR_HI while io_buffer_full=1 is not granted.
  - In that case the controller stays IDLE, and load/fetch are not granted that cycle either, which preserves order after the commit.
- Byte counter: idx 0..N-1. N=size, or 4 for fetch. Address of beat k is addr+k, modulo 2^ADDR_W.
- READ:
  - Grant edge G: mem_a<=addr, mem_wr<=0.
  - Edge G+k (1<=k<N): mem_a<=addr+k.
  - Byte j is sampled from mem_din at edge G+j+2 into bits [8j+7:8j].
  - At edge G+N+1: the matching done pulse and data are registered, then state returns to IDLE.
  - Done is therefore high during the cycle after edge G+N+1.
- Extension: signed N=1 or N=2 results are sign-extended from bit 7 or bit 15; unsigned results are zero-extended.
- WRITE:
  - Edges G..G+N-1: mem_a<=addr+k, mem_dout<=data[8k+7:8k], mem_wr<=1.
  - Edge G+N: mem_wr<=0, out_store_done pulses, state returns to IDLE.
  - An IO stall between bytes of a multi-byte store does not occur; the IO check is done at grant only.
- in_misbranch:
  - In READ: abort; state IDLE, mem_wr=0, no done; the load slot is cleared.
  - In WRITE: the write completes; the store slot is retained. Committed stores are never dropped.
  - In IDLE: the load slot is cleared.
- Back-to-back: a new grant may occur on the edge immediately after the done edge.
- mem_wr is 0 in every cycle that is not an active write beat.

Decomposition:
- Shared constants file: DATA_WIDTH, RAM_ADDRESS_WIDTH, TRUE/FALSE, IO address constant, size encodings.
- No sub-module is needed.

Test Plan:
- Fetch from 0x0000_0100 with RAM bytes 13 05 00 00 -> out_fetch_data=0x0000_0513; done exactly 5 cycles after grant.
- LB at 0x200 holding 0x80, signed -> 0xFFFF_FF80; the same access unsigned (LBU) -> 0x0000_0080; done 2 cycles after grant.
- SH at 0x300, data 0x1234_ABCD -> writes 0xCD@0x300 then 0xAB@0x301, mem_wr high exactly 2 cycles; done pulse; RAM byte 0x302 unchanged.
- Same-cycle store pulse, load pulse and fetch request -> store serviced first, then load, then fetch; each done pulses once.
- SB to 0x30000 while io_buffer_full=1 for 10 cycles -> mem_wr stays 0 and the fetch is not granted; after release, the write occurs and then the fetch.
- LW in progress plus in_misbranch at beat 2 -> no out_load_done, state IDLE; the next fetch proceeds normally. A store in progress under misbranch -> completes and done pulses.
